// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the command framer.
//   - frame constants (sync byte, highest register address, inter-byte timeout)
//   - parameter register bank address map
//   - framer state encoding
//   - ACK/NAK reply bytes, used when CMD_FRAME_ACK_EN is defined
package cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
  localparam logic [7:0] ADDR_MAX_DEF       = 8'd12;
  localparam int         TIMEOUT_CYCLES_DEF = 12000;  // 1 ms at 12 MHz

  // Register bank address map
  localparam logic [7:0] REG_PERIOD     = 8'd0;
  localparam logic [7:0] REG_P1WID      = 8'd1;
  localparam logic [7:0] REG_DELAY      = 8'd2;
  localparam logic [7:0] REG_P2WID      = 8'd3;
  localparam logic [7:0] REG_PRE_ATT    = 8'd4;
  localparam logic [7:0] REG_POST_ATT   = 8'd5;
  localparam logic [7:0] REG_CPMG       = 8'd6;
  localparam logic [7:0] REG_PBLOCK     = 8'd7;
  localparam logic [7:0] REG_PBLOCK_OFF = 8'd8;
  localparam logic [7:0] REG_BLOCK      = 8'd9;
  localparam logic [7:0] REG_PUMP       = 8'd10;
  localparam logic [7:0] REG_RSVD11     = 8'd11;
  localparam logic [7:0] REG_RSVD12     = 8'd12;

  // Reply bytes sent back after each frame result
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CHK
`ifdef CMD_FRAME_ACK_EN
    , ST_ACK
`endif
  } state_t;

endpackage

// File: rtl/cmd_timeout_ctr.sv
// cmd_timeout_ctr: reloadable inter-byte timeout counter.
//   clk, reset : clock, synchronous active-high reset
//   run        : count this cycle (framer is inside a frame)
//   reload     : force the count back to 0 (byte accepted)
//   expired    : high while running with the count at TIMEOUT_CYCLES-1
// The count is held at 0 while not running, so entering a frame always
// starts from a fresh count. It never wraps; it parks at the last value.
module cmd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 12000,
  localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expired = run && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset)                 cnt_q <= '0;
    else if (reload || !run)   cnt_q <= '0;
    else if (cnt_q != LAST)    cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: byte-level command framer feeding the pulse parameter
// register bank.
//
// Frame: SYNC, ADDR, D3, D2, D1, D0, CHK with CHK = ADDR^D3^D2^D1^D0.
// A good frame produces one wr_en pulse one cycle after CHK is accepted;
// a bad checksum (priority) or out-of-range address produces an error
// pulse instead. A frame stalled longer than TIMEOUT_CYCLES between bytes
// is dropped with an err_timeout pulse.
//
// Ports:
//   clk, reset         12 MHz clock, synchronous active-high reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   wr_en              one-cycle register write strobe
//   wr_addr, wr_data   write address/data, held until the next write
//   err_chk            one-cycle checksum mismatch pulse
//   err_addr           one-cycle address > ADDR_MAX pulse
//   err_timeout        one-cycle inter-byte timeout pulse
//   busy               high while a frame (or reply) is in progress
// Optional (macro CMD_FRAME_ACK_EN):
//   tx_data, tx_valid  reply byte (06 good / 15 any error), held until
//   tx_ready           is seen high on a clock edge
//   err_overrun        one-cycle pulse, rx byte dropped while replying
module cmd_frame_rx
  import cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0] ADDR_MAX       = ADDR_MAX_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        err_chk,
  output logic        err_addr,
  output logic        err_timeout,
  output logic        busy
`ifdef CMD_FRAME_ACK_EN
  ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err_overrun
`endif
);

  // Where a frame result (good, error or timeout) sends the FSM.
`ifdef CMD_FRAME_ACK_EN
  localparam state_t ST_DONE = ST_ACK;
`else
  localparam state_t ST_DONE = ST_IDLE;
`endif

  state_t      state_q, state_d;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic [7:0]  chk_q;
  logic [1:0]  bcnt_q;

  logic wr_d, chk_err_d, addr_err_d, to_err_d;
  logic expired, in_frame;

`ifdef CMD_FRAME_ACK_EN
  logic [7:0] ack_byte_d;
  logic       ovr_d;
`endif

  // Timer runs only while collecting frame bytes; any accepted byte reloads.
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CHK);

  cmd_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
    .clk     (clk),
    .reset   (reset),
    .run     (in_frame),
    .reload  (rx_valid),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and result decode. A byte arriving on the expiry cycle
  // is checked first, so it wins over the timeout.
  always_comb begin
    state_d    = state_q;
    wr_d       = 1'b0;
    chk_err_d  = 1'b0;
    addr_err_d = 1'b0;
    to_err_d   = 1'b0;
`ifdef CMD_FRAME_ACK_EN
    ovr_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_ADDR;
      ST_ADDR: begin
        if (rx_valid)     state_d = ST_DATA;
        else if (expired) begin to_err_d = 1'b1; state_d = ST_DONE; end
      end
      ST_DATA: begin
        // SYNC_BYTE is ordinary data here; no resync.
        if (rx_valid) begin
          if (bcnt_q == 2'd3) state_d = ST_CHK;
        end else if (expired) begin
          to_err_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_data != chk_q)    chk_err_d  = 1'b1;
          else if (addr_q > ADDR_MAX) addr_err_d = 1'b1;
          else                     wr_d       = 1'b1;
          state_d = ST_DONE;
        end else if (expired) begin
          to_err_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
`ifdef CMD_FRAME_ACK_EN
      ST_ACK: begin
        ovr_d = rx_valid;
        if (tx_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef CMD_FRAME_ACK_EN
    ack_byte_d = wr_d ? ACK_BYTE : NAK_BYTE;
`endif
  end

  // Frame datapath and registered result pulses (latency 1 after CHK).
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      bcnt_q      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      err_chk     <= 1'b0;
      err_addr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wr_en       <= wr_d;
      err_chk     <= chk_err_d;
      err_addr    <= addr_err_d;
      err_timeout <= to_err_d;
      if (wr_d) begin
        wr_addr <= addr_q;
        wr_data <= data_q;
      end
      if (rx_valid && state_q == ST_ADDR) begin
        addr_q <= rx_data;
        chk_q  <= rx_data;
        bcnt_q <= '0;
      end
      if (rx_valid && state_q == ST_DATA) begin
        data_q <= {data_q[23:0], rx_data};
        chk_q  <= chk_q ^ rx_data;
        bcnt_q <= bcnt_q + 2'd1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef CMD_FRAME_ACK_EN
  // Reply byte is captured on entry to ACK and held until tx_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= ovr_d;
      if (state_d == ST_ACK && state_q != ST_ACK) tx_data <= ack_byte_d;
    end
  end

  assign tx_valid = (state_q == ST_ACK);
`endif

endmodule

// File: tb/tb_cmd_frame_rx.sv
// tb_cmd_frame_rx: directed self-checking bench for cmd_frame_rx.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, and pulse counters sample 1 time unit after the rising edge.
module tb_cmd_frame_rx;

  localparam int TO = 12000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_chk, err_addr, err_timeout, busy;
`ifdef CMD_FRAME_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        err_overrun;
`endif

  cmd_frame_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .err_chk     (err_chk),
    .err_addr    (err_addr),
    .err_timeout (err_timeout),
    .busy        (busy)
`ifdef CMD_FRAME_ACK_EN
    ,
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .err_overrun (err_overrun)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0, chk_cnt = 0, addr_cnt = 0, to_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (wr_en)       wr_cnt++;
    if (err_chk)     chk_cnt++;
    if (err_addr)    addr_cnt++;
    if (err_timeout) to_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_cnt = 0; chk_cnt = 0; addr_cnt = 0; to_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(c);
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_errs",    32'({err_chk, err_addr, err_timeout}), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    reset = 1'b0;
    idle(1);

    // Good frame
    clr();
    send_frame(8'h01, 32'h000003E8, 8'hEA);
    check("good_wr_en_lat1", 32'(wr_en), 32'd1);
    check("good_wr_addr",    32'(wr_addr), 32'h01);
    check("good_wr_data",    wr_data, 32'h000003E8);
    idle(1);
    check("good_wr_en_1cyc", 32'(wr_en), 32'd0);
    idle(2);
    check("good_busy_after", 32'(busy), 32'd0);
    check("good_wr_cnt",     wr_cnt, 32'd1);

    // Bad checksum
    clr();
    send_frame(8'h01, 32'h000003E8, 8'hEB);
    check("badchk_err_chk", 32'(err_chk), 32'd1);
    check("badchk_wr_en",   32'(wr_en), 32'd0);
    idle(3);
    check("badchk_cnt",     chk_cnt, 32'd1);
    check("badchk_no_wr",   wr_cnt, 32'd0);
    check("badchk_wr_data", wr_data, 32'h000003E8);

    // Address out of range
    clr();
    send_frame(8'h20, 32'h00000005, 8'h25);
    check("badaddr_err_addr", 32'(err_addr), 32'd1);
    check("badaddr_err_chk",  32'(err_chk), 32'd0);
    idle(3);
    check("badaddr_no_wr",    wr_cnt, 32'd0);
    check("badaddr_cnt",      addr_cnt, 32'd1);

    // Both errors: checksum wins
    send_frame(8'h20, 32'h00000005, 8'h26);
    check("both_err_chk",  32'(err_chk), 32'd1);
    check("both_err_addr", 32'(err_addr), 32'd0);
    idle(3);

    // Address boundary: 0C accepted, 0D rejected
    clr();
    send_frame(8'h0C, 32'h00000001, 8'h0D);
    check("addr_max_wr_en", 32'(wr_en), 32'd1);
    check("addr_max_addr",  32'(wr_addr), 32'h0C);
    idle(3);
    send_frame(8'h0D, 32'h00000001, 8'h0C);
    check("addr_max1_err", 32'(err_addr), 32'd1);
    idle(3);
    check("addr_bound_wr_cnt", wr_cnt, 32'd1);

    // Leading garbage, then a valid frame
    clr();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    idle(1);
    check("garbage_busy", 32'(busy), 32'd0);
    send_frame(8'h02, 32'h12345678, 8'h0A);
    idle(3);
    check("garbage_wr_cnt", wr_cnt, 32'd1);
    check("garbage_addr",   32'(wr_addr), 32'h02);
    check("garbage_data",   wr_data, 32'h12345678);

    // SYNC value inside the data field is plain data
    send_frame(8'h03, 32'hA5000001, 8'hA7);
    idle(3);
    check("sync_in_data", wr_data, 32'hA5000001);

`ifndef CMD_FRAME_ACK_EN
    // Back-to-back: second SYNC arrives in the wr_en cycle
    clr();
    send_frame(8'h04, 32'h00000010, 8'h14);
    send_frame(8'h05, 32'h00000020, 8'h25);
    idle(3);
    check("b2b_wr_cnt", wr_cnt, 32'd2);
    check("b2b_addr",   32'(wr_addr), 32'h05);
    check("b2b_data",   wr_data, 32'h00000020);
`endif

    // Timeout, case A: pulse exactly TO cycles after the last byte
    clr();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    idle(TO - 1);
    check("to_not_early",  to_cnt, 32'd0);
    check("to_busy_wait",  32'(busy), 32'd1);
    idle(1);
    check("to_pulse",      32'(err_timeout), 32'd1);
    idle(3);
    check("to_once",       to_cnt, 32'd1);
    check("to_busy_after", 32'(busy), 32'd0);
    send_frame(8'h06, 32'h00000007, 8'h01);
    idle(3);
    check("to_next_wr",    wr_cnt, 32'd1);
    check("to_next_data",  wr_data, 32'h00000007);

    // Byte on the expiry cycle wins
    clr();
    send_byte(8'hA5);
    idle(TO - 1);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(3);
    check("tie_no_to", to_cnt, 32'd0);
    check("tie_wr",    wr_cnt, 32'd1);
    check("tie_addr",  32'(wr_addr), 32'h03);

    // Timeout, case B: reset mid-frame
    clr();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rstmid_busy",    32'(busy), 32'd0);
    check("rstmid_wr_data", wr_data, 32'd0);
    idle(3);
    check("rstmid_no_pulse", wr_cnt + chk_cnt + addr_cnt + to_cnt, 32'd0);
    send_frame(8'h07, 32'h0000000A, 8'h0D);
    idle(3);
    check("rstmid_next_wr",   wr_cnt, 32'd1);
    check("rstmid_next_addr", 32'(wr_addr), 32'h07);

`ifdef CMD_FRAME_ACK_EN
    // ACK held while tx_ready is low
    tx_ready = 1'b0;
    send_frame(8'h01, 32'h000003E8, 8'hEA);
    for (int i = 0; i < 5; i++) begin
      check("ack_hold_valid", 32'(tx_valid), 32'd1);
      check("ack_hold_data",  32'(tx_data), 32'h06);
      idle(1);
    end
    tx_ready = 1'b1;
    idle(1);
    check("ack_release", 32'(tx_valid), 32'd0);
    // NAK on a bad frame
    tx_ready = 1'b0;
    send_frame(8'h01, 32'h000003E8, 8'hEB);
    check("nak_valid", 32'(tx_valid), 32'd1);
    check("nak_data",  32'(tx_data), 32'h15);
    tx_ready = 1'b1;
    idle(2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmd_frame_rx.md
Name: cmd_frame_rx

Overview:
- Byte-level command framer between the UART byte receiver (12 MHz `clk` domain) and the pulse parameter register bank.
- Assembles fixed-length frames from received bytes and checks them (checksum, address range, inter-byte timeout).
- Issues one single-cycle register write per good frame; the register bank drives period, p1width, delay, p2width, attenuators, cpmg and block settings.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_MAX, 8'd12, highest valid register address (inclusive).
- TIMEOUT_CYCLES, 12000, max clk cycles between bytes inside a frame (1 ms at 12 MHz).

Ports:
- clk  in  1  12 MHz system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- wr_en  out  1  one-cycle register write strobe
- wr_addr  out  8  register address, held until next write
- wr_data  out  32  register data, big-endian assembled, held until next write
- err_chk  out  1  one-cycle pulse, checksum mismatch
- err_addr  out  1  one-cycle pulse, address > ADDR_MAX
- err_timeout  out  1  one-cycle pulse, inter-byte timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; shift register 0; checksum 0; timeout counter 0.
- Frame format: SYNC, ADDR, D3, D2, D1, D0, CHK. CHK = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> ADDR.
  - Any other byte is discarded silently.
- ADDR: latch byte into addr register, seed checksum with it, clear byte counter -> DATA.
- DATA:
  - Each byte shifts in MSB-first: data <= {data[23:0], byte]; checksum ^= byte.
  - After the 4th byte -> CHK.
  - A SYNC_BYTE value here is treated as data; there is no resync.
- CHK, on rx_valid:
  - Checksum mismatch -> err_chk.
  - Else addr > ADDR_MAX -> err_addr.
  - Else wr_en.
  - Result appears the cycle after CHK is accepted (latency 1), then -> IDLE.
  - wr_addr/wr_data update only on wr_en.
  - When both errors apply, err_chk takes priority.
- Timeout:
  - Counter reloads to 0 on every accepted byte and on entry to a non-IDLE state; it increments each cycle outside IDLE.
  - Reaching TIMEOUT_CYCLES-1 -> err_timeout pulse, -> IDLE, partial frame dropped.
  - rx_valid in the same cycle as expiry: the byte wins, counter reloads, no error.
- Throughput: back-to-back frames are accepted; SYNC may arrive on the same cycle wr_en is asserted.
- Reset mid-frame: immediate return to IDLE, no write, no error pulse.
- Width: the counter is sized $clog2(TIMEOUT_CYCLES); no wrap inside a frame.

Optional Feature:
- Macro: CMD_FRAME_ACK_EN.
- When defined:
  - Adds ports tx_data[7:0] out, tx_valid out, tx_ready in.
  - Adds state ACK after each frame result: drive 8'h06 on success, 8'h15 on any error, including timeout.
  - Hold tx_valid until tx_ready is seen high on a clock edge, then -> IDLE.
  - rx bytes arriving in ACK are dropped and pulse an extra output err_overrun.
  - tx_valid resets to 0.
- When undefined: no tx ports or ACK state, and results go straight to IDLE.

Decomposition:
- Shared package cmd_pkg holds:
  - Register address constants: REG_PERIOD=0, REG_P1WID=1, REG_DELAY=2, REG_P2WID=3, REG_PRE_ATT=4, REG_POST_ATT=5, REG_CPMG=6, REG_PBLOCK=7, REG_PBLOCK_OFF=8, REG_BLOCK=9, REG_PUMP=10, through 12.
  - State enum.
  - ACK/NAK byte constants.
- One sub-module, cmd_timeout_ctr: reloadable counter with an expiry pulse.

Test Plan:
- Good frame: bytes A5 01 00 00 03 E8 EA -> one wr_en pulse, wr_addr=8'h01, wr_data=32'h000003E8, busy low afterwards.
- Bad checksum: A5 01 00 00 03 E8 EB -> err_chk one cycle, no wr_en, wr_data unchanged.
- Out-of-range address: A5 20 00 00 00 05 25 -> err_addr, no wr_en.
- Leading garbage: 00 FF 3C, then a valid frame with ADDR 02 and data 12345678 (CHK=0A) -> garbage ignored, wr_addr=02, wr_data=32'h12345678.
- Timeout and reset:
  - Case A: send A5 03 11, then idle TIMEOUT_CYCLES cycles -> err_timeout once, busy low; a following valid frame is accepted.
  - Case B: send A5 03 11, then assert reset for 1 cycle -> no error pulse; a following valid frame is accepted.
- ACK (with CMD_FRAME_ACK_EN):
  - Good frame with tx_ready held low 5 cycles -> tx_valid stays high with tx_data=06 until tx_ready rises.
  - A bad frame -> tx_data=15.
